// File: rtl/define_state.sv
// Shared arbiter types: FSM state enum, requester indices and the read-tag format.
package define_state;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 18;
  localparam int unsigned DATA_W  = 16;

  localparam logic [1:0] REQ_UART = 2'd0;
  localparam logic [1:0] REQ_M2   = 2'd1;
  localparam logic [1:0] REQ_M1   = 2'd2;
  localparam logic [1:0] REQ_VGA  = 2'd3;

  typedef enum logic [1:0] {
    S_ARB_IDLE       = 2'd0,
    S_ARB_GRANT      = 2'd1,
    S_ARB_TURNAROUND = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] id;
  } rd_tag_t;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sram_arb_priority_enc.sv
// Fixed-priority encoder: lowest-indexed asserted request wins.
module sram_arb_priority_enc
  import define_state::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic               o_any
);

  // Two's-complement trick isolates the lowest set bit.
  assign o_onehot = i_req & (~i_req + NUM_REQ'(1));
  assign o_any    = |i_req;

endmodule

// File: rtl/sram_arbiter.sv
// Four-way fixed-priority SRAM bus arbiter with tagged read-valid pipeline.
// Optional ownership timeout compiled in with SRAM_ARB_TIMEOUT_EN.
module sram_arbiter
  import define_state::*;
#(
  parameter int unsigned READ_LATENCY   = 2,
  parameter logic [25:0] TIMEOUT_CYCLES = 26'd49999999
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_address,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_write_data,
  input  logic [NUM_REQ-1:0]               req_we_n,
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_REQ-1:0]               read_valid,
  output logic [ADDR_W-1:0]                SRAM_address,
  output logic [DATA_W-1:0]                SRAM_write_data,
  output logic                             SRAM_we_n,
  output logic [1:0]                       owner,
  output logic                             timeout_error
);

  arb_state_e          r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic [1:0]          r_owner;
  logic [ADDR_W-1:0]   r_last_addr;
  rd_tag_t             r_pipe [READ_LATENCY];

  logic [NUM_REQ-1:0]  w_blocked;
  logic [NUM_REQ-1:0]  w_req_elig;
  logic [NUM_REQ-1:0]  w_sel_oh;
  logic                w_sel_any;
  logic                w_timeout_hit;
  logic                w_revoke;
  logic                w_rd_issue;

  assign w_req_elig = req & ~w_blocked;
  assign w_revoke   = !req[r_owner] || w_timeout_hit;
  assign w_rd_issue = (r_state == S_ARB_GRANT) && req_we_n[r_owner];

  sram_arb_priority_enc u_prio (
    .i_req    (w_req_elig),
    .o_onehot (w_sel_oh),
    .o_any    (w_sel_any)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= S_ARB_IDLE;
      r_grant     <= '0;
      r_owner     <= REQ_VGA;
      r_last_addr <= '0;
    end else begin
      case (r_state)
        S_ARB_IDLE, S_ARB_TURNAROUND: begin
          if (w_sel_any) begin
            r_state <= S_ARB_GRANT;
            r_grant <= w_sel_oh;
            r_owner <= onehot_to_idx(w_sel_oh);
          end else begin
            r_state <= S_ARB_IDLE;
            r_grant <= '0;
          end
        end
        S_ARB_GRANT: begin
          r_last_addr <= req_address[r_owner];
          if (w_revoke) begin
            r_state <= S_ARB_TURNAROUND;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= S_ARB_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  // Tags travel with the read so completions survive an ownership change.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= {w_rd_issue, r_owner};
      for (int i = 1; i < int'(READ_LATENCY); i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_comb begin
    read_valid = '0;
    if (r_pipe[READ_LATENCY-1].valid) read_valid[r_pipe[READ_LATENCY-1].id] = 1'b1;
  end

  always_comb begin
    if (r_state == S_ARB_GRANT) begin
      SRAM_address    = req_address[r_owner];
      SRAM_write_data = req_write_data[r_owner];
      SRAM_we_n       = req_we_n[r_owner];
    end else begin
      SRAM_address    = r_last_addr;
      SRAM_write_data = '0;
      SRAM_we_n       = 1'b1;
    end
  end

  assign grant = r_grant;
  assign owner = r_owner;

`ifdef SRAM_ARB_TIMEOUT_EN
  logic [25:0]        r_tmo_cnt;
  logic [NUM_REQ-1:0] r_blocked;
  logic               r_tmo_err;

  assign w_timeout_hit = (r_state == S_ARB_GRANT) && (r_tmo_cnt == TIMEOUT_CYCLES - 26'd1);
  assign w_blocked     = r_blocked;
  assign timeout_error = r_tmo_err;

  // A revoked requester stays masked until it lets go of req.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_tmo_cnt <= '0;
      r_blocked <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == S_ARB_GRANT) ? r_tmo_cnt + 26'd1 : '0;
      r_blocked <= (r_blocked & req) | (w_timeout_hit ? r_grant : '0);
      if (w_timeout_hit) r_tmo_err <= 1'b1;
    end
  end
`else
  assign w_timeout_hit = 1'b0;
  assign w_blocked     = '0;
  assign timeout_error = 1'b0;
`endif

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2: cycles from an issued SRAM read to valid SRAM_read_data.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 26'd49999999: maximum ownership length when timeout is compiled in.
REQ-003 SHALL have port Clock, input, 1: the single 50 MHz clock; all logic is on its rising edge.
REQ-004 SHALL have port Reset, input, 1: reset that is synchronous and active-high.
REQ-005 SHALL have port req, input, 4: request lines, one per requester; index 0 = UART, 1 = Milestone 2, 2 = Milestone 1, 3 = VGA.
REQ-006 SHALL have port req_address, input, 4x18: SRAM address from each requester.
REQ-007 SHALL have port req_write_data, input, 4x16: SRAM write data from each requester.
REQ-008 SHALL have port req_we_n, input, 4x1: active-low write enable from each requester.
REQ-009 SHALL have port grant, output, 4: one-hot grant; all-zero when no requester owns the bus.
REQ-010 SHALL have port read_valid, output, 4: one-hot pulse that marks SRAM_read_data valid for a requester.
REQ-011 SHALL have port SRAM_address, output, 18: address to the SRAM controller.
REQ-012 SHALL have port SRAM_write_data, output, 16: write data to the SRAM controller.
REQ-013 SHALL have port SRAM_we_n, output, 1: write enable to the SRAM controller.
REQ-014 SHALL have port owner, output, 2: index of the current or last owner, for the LED display.
REQ-015 SHALL have port timeout_error, output, 1: sticky flag set on a forced revoke.

Function
REQ-016 SHALL run a three-state FSM:
- S_ARB_IDLE: no owner.
- S_ARB_GRANT: one requester owns the bus.
- S_ARB_TURNAROUND: one cycle between owners.
REQ-017 SHALL, in S_ARB_IDLE, sample req and select the lowest-indexed asserted bit (fixed priority); the selected grant bit rises the following cycle in S_ARB_GRANT.
REQ-018 SHALL hold a grant, without preemption, for as long as the owner keeps its req asserted.
REQ-019 SHALL move to S_ARB_TURNAROUND on the cycle after the owner deasserts req, with grant = 0.
REQ-020 SHALL go from S_ARB_TURNAROUND to S_ARB_GRANT if any req is asserted, arbitrating per REQ-017; otherwise it SHALL go to S_ARB_IDLE.
REQ-021 SHALL drive SRAM_address, SRAM_write_data and SRAM_we_n combinationally from the granted requester's inputs in S_ARB_GRANT.
REQ-022 SHALL, outside S_ARB_GRANT, drive SRAM_we_n = 1, hold SRAM_address at the last owner's final value, and drive SRAM_write_data = 0.
REQ-023 SHALL treat each S_ARB_GRANT cycle with the owner's req_we_n = 1 as a read, and pulse read_valid[owner] exactly READ_LATENCY cycles later.
REQ-024 SHALL implement REQ-023 with a READ_LATENCY-deep shift register of {valid, id}, so that reads still in flight complete after an ownership change.
REQ-025 SHALL ignore req bits that rise during S_ARB_GRANT until the next arbitration point.
REQ-026 SHALL honour simultaneous requests by priority only; a lower-priority requester waits for as long as higher-priority requests keep arriving.
REQ-027 SHALL update owner on every grant and keep it through S_ARB_IDLE and S_ARB_TURNAROUND.

Reset
REQ-028 SHALL, on Reset = 1 at a clock edge, set: state S_ARB_IDLE, grant 0, read_valid 0, the latency pipeline cleared, SRAM_we_n 1, SRAM_address 0, SRAM_write_data 0, owner 3, timeout_error 0.
REQ-029 SHALL, when Reset asserts mid-burst, drop grant and SRAM_we_n = 1 on the next edge and issue no read_valid for in-flight reads.

Configuration
REQ-030 SHALL, with SRAM_ARB_TIMEOUT_EN defined:
- count cycles of continuous ownership;
- when the count reaches TIMEOUT_CYCLES, force S_ARB_TURNAROUND and set timeout_error;
- ignore the revoked requester until it deasserts req.
REQ-031 SHALL, without SRAM_ARB_TIMEOUT_EN, contain no timeout counter and tie timeout_error to 0.

Structure
REQ-032 SHALL take the state enum (S_ARB_IDLE, S_ARB_GRANT, S_ARB_TURNAROUND) and the requester index constants (REQ_UART = 0, REQ_M2 = 1, REQ_M1 = 2, REQ_VGA = 3) from the shared define_state package.
REQ-033 SHALL contain a single sub-module, sram_arb_priority_enc: a combinational 4-bit priority encoder with a one-hot output and an any-request output.

Verification
REQ-034 SHALL cover single request: req = 4'b0100 at cycle 0 -> grant = 4'b0100 at cycle 1; SRAM_address equals req_address[2].
REQ-035 SHALL cover contention: req = 4'b1011 -> grant 4'b0001; req[0] drops at cycle 5 -> grant 0 and we_n 1 at cycle 6; grant 4'b0010 at cycle 7.
REQ-036 SHALL cover read tagging: owner 3 reads at cycles 2–4, then hands over to owner 0 -> read_valid[3] pulses at cycles 4–6 and none are lost.
REQ-037 SHALL cover reset mid-write: Reset asserted while owner 1 has we_n = 0 -> next edge gives grant 0, SRAM_we_n 1, read_valid 0.
REQ-038 SHALL cover timeout: with SRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, req[2] held -> revoked after 8 grant cycles and timeout_error = 1; req[2] is not regranted until it drops.
REQ-039 SHALL cover the idle gap: req goes to 0 after a grant -> the FSM passes S_ARB_TURNAROUND then S_ARB_IDLE, and SRAM_we_n stays 1 throughout.
